// File: rtl/cus19_mem_pkg.sv
// Shared types and constants for the Custom19 masked-write data memory.
package cus19_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

    // Collision policy: which word a same-address read sees
    localparam bit RD_FIRST = 1'b0;
    localparam bit WR_FIRST = 1'b1;

    // Index width that covers 0..depth-1, never less than one bit
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cus19_mem_init_seq.sv
// Post-reset zero-init sweep: walks every implemented word once, then raises ready.
module cus19_mem_init_seq
    import cus19_mem_pkg::*;
#(
    parameter int Mem_Depth = 2048,
    localparam int CntW     = idx_width(Mem_Depth)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    output logic            init_we,
    output logic [CntW-1:0] init_addr,
    output logic            ready
);

    localparam logic [CntW-1:0] LAST = CntW'(Mem_Depth - 1);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LAST) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    // ready rises on the same edge that writes the last word
    always_comb begin
        init_we   = (state_q == ST_INIT) && !rst_in;
        init_addr = cnt_q;
        ready     = (state_q == ST_RUN);
    end

endmodule

// File: rtl/cus19_data_memory_mw.sv
// Custom19 data memory: 1R/1W, per-bit write mask, range check, optional output register.
module cus19_data_memory_mw
    import cus19_mem_pkg::*;
#(
    parameter int Mem_Addr_Width = 11,
    parameter int Data_Width     = 19,
    parameter int Mem_Depth      = 2048,
    parameter int Out_Reg        = 0,
    parameter int Wr_First       = 0
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      mem_rd_in,
    input  logic [Mem_Addr_Width-1:0] rd_addr_in,
    input  logic                      mem_wr_in,
    input  logic [Mem_Addr_Width-1:0] wr_addr_in,
    input  logic [Data_Width-1:0]     wr_data_in,
    input  logic [Data_Width-1:0]     wr_mask_in,
    output logic [Data_Width-1:0]     rd_data_out,
    output logic                      rd_valid_out,
    output logic                      ready_out,
    output logic                      addr_err_out
);

    localparam int                    IDX_W  = idx_width(Mem_Depth);
    localparam logic [Mem_Addr_Width:0] DEPTH = (Mem_Addr_Width + 1)'(Mem_Depth);
    localparam bit                    POLICY = (Wr_First != 0) ? WR_FIRST : RD_FIRST;

    logic [Data_Width-1:0] mem_q [Mem_Depth];

    logic             init_we, run;
    logic [IDX_W-1:0] init_addr;

    cus19_mem_init_seq #(.Mem_Depth(Mem_Depth)) u_init (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (run)
    );

    assign ready_out = run;

    logic                  rd_req, wr_req, rd_ok, wr_ok, collide;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic [Data_Width-1:0] merged, rd_word;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [Data_Width-1:0] mem_wdata;

    always_comb begin
        rd_req  = run && mem_rd_in;
        wr_req  = run && mem_wr_in;
        rd_ok   = rd_req && ({1'b0, rd_addr_in} < DEPTH);
        wr_ok   = wr_req && ({1'b0, wr_addr_in} < DEPTH);
        rd_idx  = rd_addr_in[IDX_W-1:0];
        wr_idx  = wr_addr_in[IDX_W-1:0];
        merged  = (mem_q[wr_idx] & ~wr_mask_in) | (wr_data_in & wr_mask_in);
        collide = rd_ok && wr_ok && (rd_addr_in == wr_addr_in);
        rd_word = '0;
        if (rd_ok)
            rd_word = (collide && POLICY == WR_FIRST) ? merged : mem_q[rd_idx];
        // sweep owns the write port until ready; user writes are ignored meanwhile
        mem_we    = init_we || wr_ok;
        mem_waddr = init_we ? init_addr : wr_idx;
        mem_wdata = init_we ? '0 : merged;
    end

    always_ff @(posedge clk_in) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    logic                  s1_vld_q, s1_vld_d;
    logic [Data_Width-1:0] s1_data_q, s1_data_d;
    logic                  s1_rerr_q, s1_rerr_d;
    logic                  wr_err_q, wr_err_d;

    always_comb begin
        s1_vld_d  = rd_req;
        s1_data_d = rd_req ? rd_word : s1_data_q;
        s1_rerr_d = rd_req && !rd_ok;
        wr_err_d  = wr_req && !wr_ok;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_rerr_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s1_rerr_q <= s1_rerr_d;
            wr_err_q  <= wr_err_d;
        end
    end

    generate
        if (Out_Reg != 0) begin : g_out_reg
            logic                  s2_vld_q, s2_vld_d;
            logic [Data_Width-1:0] s2_data_q, s2_data_d;
            logic                  s2_rerr_q, s2_rerr_d;

            always_comb begin
                s2_vld_d  = s1_vld_q;
                s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
                s2_rerr_d = s1_rerr_q;
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    s2_vld_q  <= 1'b0;
                    s2_data_q <= '0;
                    s2_rerr_q <= 1'b0;
                end else begin
                    s2_vld_q  <= s2_vld_d;
                    s2_data_q <= s2_data_d;
                    s2_rerr_q <= s2_rerr_d;
                end
            end

            // read errors follow read latency; write errors stay one cycle after request
            assign rd_data_out  = s2_data_q;
            assign rd_valid_out = s2_vld_q;
            assign addr_err_out = s2_rerr_q | wr_err_q;
        end else begin : g_no_out_reg
            assign rd_data_out  = s1_data_q;
            assign rd_valid_out = s1_vld_q;
            assign addr_err_out = s1_rerr_q | wr_err_q;
        end
    endgenerate

endmodule

// File: tb/tb_cus19_data_memory_mw.sv
// Directed bench: four memory variants (depth / output register / collision policy) on shared stimulus.
module tb_cus19_data_memory_mw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0;
    logic [10:0] ra = '0, wa = '0;
    logic [18:0] wd = '0, wm = '0;

    logic [18:0] dout [4];
    logic        vld [4], rdy [4], err [4];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // u0: base, u1: write-first, u2: depth 12, u3: output register
    cus19_data_memory_mw #(.Mem_Depth(16), .Out_Reg(0), .Wr_First(0)) u0 (
        .clk_in(clk), .rst_in(rst), .mem_rd_in(rd), .rd_addr_in(ra), .mem_wr_in(wr),
        .wr_addr_in(wa), .wr_data_in(wd), .wr_mask_in(wm), .rd_data_out(dout[0]),
        .rd_valid_out(vld[0]), .ready_out(rdy[0]), .addr_err_out(err[0]));
    cus19_data_memory_mw #(.Mem_Depth(16), .Out_Reg(0), .Wr_First(1)) u1 (
        .clk_in(clk), .rst_in(rst), .mem_rd_in(rd), .rd_addr_in(ra), .mem_wr_in(wr),
        .wr_addr_in(wa), .wr_data_in(wd), .wr_mask_in(wm), .rd_data_out(dout[1]),
        .rd_valid_out(vld[1]), .ready_out(rdy[1]), .addr_err_out(err[1]));
    cus19_data_memory_mw #(.Mem_Depth(12), .Out_Reg(0), .Wr_First(0)) u2 (
        .clk_in(clk), .rst_in(rst), .mem_rd_in(rd), .rd_addr_in(ra), .mem_wr_in(wr),
        .wr_addr_in(wa), .wr_data_in(wd), .wr_mask_in(wm), .rd_data_out(dout[2]),
        .rd_valid_out(vld[2]), .ready_out(rdy[2]), .addr_err_out(err[2]));
    cus19_data_memory_mw #(.Mem_Depth(16), .Out_Reg(1), .Wr_First(0)) u3 (
        .clk_in(clk), .rst_in(rst), .mem_rd_in(rd), .rd_addr_in(ra), .mem_wr_in(wr),
        .wr_addr_in(wa), .wr_data_in(wd), .wr_mask_in(wm), .rd_data_out(dout[3]),
        .rd_valid_out(vld[3]), .ready_out(rdy[3]), .addr_err_out(err[3]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int f0, f2;
        rst = 1'b1;
        tick(); tick();
        for (int d = 0; d < 4; d++) begin
            n_chk++; if (rdy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 0", d, rdy[d]); end
            n_chk++; if (vld[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", d, vld[d]); end
            n_chk++; if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got %b want 0", d, err[d]); end
            n_chk++; if (dout[d] !== 19'h0) begin n_fail++; $display("FAIL reset_data[%0d] got %h want 0", d, dout[d]); end
        end
        rst = 1'b0;
        f0 = 0; f2 = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rdy[0] && f0 == 0) f0 = i;
            if (rdy[2] && f2 == 0) f2 = i;
        end
        n_chk++; if (f0 != 16) begin n_fail++; $display("FAIL ready_latency_d16 got %0d want 16", f0); end
        n_chk++; if (f2 != 12) begin n_fail++; $display("FAIL ready_latency_d12 got %0d want 12", f2); end
    endtask

    task automatic test_zero_fill;
        rd = 1'b1;
        for (int a = 0; a < 16; a++) begin
            ra = 11'(a);
            tick();
            n_chk++;
            if ({vld[0], dout[0]} !== {1'b1, 19'h0}) begin
                n_fail++; $display("FAIL zero_fill[%0d] got vld=%b data=%h want vld=1 data=0", a, vld[0], dout[0]);
            end
        end
        rd = 1'b0;
        tick();
        n_chk++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL zero_fill_idle_valid got %b want 0", vld[0]); end
    endtask

    task automatic test_mask;
        wr = 1'b1; wa = 11'd5; wd = 19'h7FFFF; wm = 19'h7FFFF;
        tick();
        wd = 19'h00000; wm = 19'h000FF;
        tick();
        wd = 19'h7FFFF; wm = 19'h00000;
        tick();
        wr = 1'b0;
        n_chk++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL mask_write_only_valid got %b want 0", vld[0]); end
        rd = 1'b1; ra = 11'd5;
        tick();
        rd = 1'b0;
        n_chk++; if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL mask_read_valid got %b want 1", vld[0]); end
        n_chk++; if (dout[0] !== 19'h7FF00) begin n_fail++; $display("FAIL mask_read_data got %h want 7ff00", dout[0]); end
        tick();
        n_chk++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL mask_valid_pulse got %b want 0", vld[0]); end
        n_chk++; if (dout[0] !== 19'h7FF00) begin n_fail++; $display("FAIL mask_data_hold got %h want 7ff00", dout[0]); end
    endtask

    task automatic test_collision;
        wr = 1'b1; wa = 11'd3; wd = 19'h12345; wm = 19'h7FFFF;
        tick();
        rd = 1'b1; ra = 11'd3; wd = 19'h55555;
        tick();
        wr = 1'b0;
        n_chk++; if (dout[0] !== 19'h12345) begin n_fail++; $display("FAIL collide_rd_first got %h want 12345", dout[0]); end
        n_chk++; if (dout[1] !== 19'h55555) begin n_fail++; $display("FAIL collide_wr_first got %h want 55555", dout[1]); end
        n_chk++; if (vld[0] !== 1'b1 || vld[1] !== 1'b1) begin n_fail++; $display("FAIL collide_valid got %b%b want 11", vld[0], vld[1]); end
        tick();
        rd = 1'b0;
        n_chk++; if (dout[0] !== 19'h55555) begin n_fail++; $display("FAIL collide_after_rd_first got %h want 55555", dout[0]); end
        n_chk++; if (dout[1] !== 19'h55555) begin n_fail++; $display("FAIL collide_after_wr_first got %h want 55555", dout[1]); end
    endtask

    task automatic test_out_of_range;
        wr = 1'b1; wa = 11'd13; wd = 19'h2AAAA; wm = 19'h7FFFF;
        tick();
        wr = 1'b0;
        n_chk++; if (err[2] !== 1'b1) begin n_fail++; $display("FAIL oob_write_err got %b want 1", err[2]); end
        n_chk++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL inrange_write_err got %b want 0", err[0]); end
        n_chk++; if (vld[2] !== 1'b0) begin n_fail++; $display("FAIL oob_write_valid got %b want 0", vld[2]); end
        rd = 1'b1; ra = 11'd5;
        tick();
        n_chk++; if (err[2] !== 1'b0) begin n_fail++; $display("FAIL oob_err_pulse got %b want 0", err[2]); end
        n_chk++; if (dout[2] !== 19'h7FF00) begin n_fail++; $display("FAIL d12_read5 got %h want 7ff00", dout[2]); end
        ra = 11'd13;
        tick();
        n_chk++; if ({vld[2], err[2], dout[2]} !== {2'b11, 19'h0}) begin
            n_fail++; $display("FAIL oob_read13 got vld=%b err=%b data=%h want 1 1 0", vld[2], err[2], dout[2]); end
        n_chk++; if ({err[0], dout[0]} !== {1'b0, 19'h2AAAA}) begin
            n_fail++; $display("FAIL d16_read13 got err=%b data=%h want 0 2aaaa", err[0], dout[0]); end
        ra = 11'd12;
        tick();
        n_chk++; if ({vld[2], err[2]} !== 2'b11) begin n_fail++; $display("FAIL oob_read12 got vld=%b err=%b want 1 1", vld[2], err[2]); end
        ra = 11'd11;
        tick();
        n_chk++; if ({vld[2], err[2], dout[2]} !== {2'b10, 19'h0}) begin
            n_fail++; $display("FAIL edge_read11 got vld=%b err=%b data=%h want 1 0 0", vld[2], err[2], dout[2]); end
        ra = 11'd14; wr = 1'b1; wa = 11'd15;
        tick();
        rd = 1'b0; wr = 1'b0;
        n_chk++; if (err[2] !== 1'b1) begin n_fail++; $display("FAIL oob_both_err got %b want 1", err[2]); end
        tick();
        n_chk++; if (err[2] !== 1'b0) begin n_fail++; $display("FAIL oob_both_single_pulse got %b want 0", err[2]); end
    endtask

    task automatic test_back_to_back;
        wr = 1'b1; wm = 19'h7FFFF; wa = 11'd1; wd = 19'h11111;
        tick();
        wa = 11'd2; wd = 19'h22222;
        tick();
        wr = 1'b0;
        rd = 1'b1; ra = 11'd1;
        tick();
        n_chk++; if (vld[3] !== 1'b0) begin n_fail++; $display("FAIL pipe_lat1_valid got %b want 0", vld[3]); end
        ra = 11'd2;
        tick();
        n_chk++; if ({vld[3], dout[3]} !== {1'b1, 19'h11111}) begin n_fail++; $display("FAIL pipe_rd1 got %b %h want 1 11111", vld[3], dout[3]); end
        ra = 11'd3;
        tick();
        n_chk++; if ({vld[3], dout[3]} !== {1'b1, 19'h22222}) begin n_fail++; $display("FAIL pipe_rd2 got %b %h want 1 22222", vld[3], dout[3]); end
        rd = 1'b0;
        tick();
        n_chk++; if ({vld[3], dout[3]} !== {1'b1, 19'h55555}) begin n_fail++; $display("FAIL pipe_rd3 got %b %h want 1 55555", vld[3], dout[3]); end
        tick();
        n_chk++; if ({vld[3], dout[3]} !== {1'b0, 19'h55555}) begin n_fail++; $display("FAIL pipe_drain got %b %h want 0 55555", vld[3], dout[3]); end
    endtask

    task automatic test_sweep_reset;
        int f;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL sweep_mid_ready got %b want 0", rdy[0]); end
        rst = 1'b1;
        tick();
        n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL sweep_rst_ready got %b want 0", rdy[0]); end
        rst = 1'b0;
        rd = 1'b1; ra = 11'd0; wr = 1'b1; wa = 11'd0; wd = 19'h7FFFF; wm = 19'h7FFFF;
        f = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_chk++; if ({vld[0], err[0]} !== 2'b00) begin
                n_fail++; $display("FAIL sweep_ignore[%0d] got vld=%b err=%b want 0 0", i, vld[0], err[0]); end
            if (rdy[0]) begin f = i; break; end
        end
        rd = 1'b0; wr = 1'b0;
        n_chk++; if (f != 16) begin n_fail++; $display("FAIL sweep_restart_latency got %0d want 16", f); end
        rd = 1'b1; ra = 11'd0;
        tick();
        n_chk++; if ({vld[0], dout[0]} !== {1'b1, 19'h0}) begin n_fail++; $display("FAIL sweep_addr0 got %b %h want 1 0", vld[0], dout[0]); end
        ra = 11'd5;
        tick();
        rd = 1'b0;
        n_chk++; if ({vld[0], dout[0]} !== {1'b1, 19'h0}) begin n_fail++; $display("FAIL sweep_addr5 got %b %h want 1 0", vld[0], dout[0]); end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_mask();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_sweep_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
